// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw board levels in, debounced levels and edge strobes out.
`timescale 1ns/1ps
interface sw_debounce_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit two-flop synchroniser and stable-count debouncer for board switches/keys,
// producing clean levels plus registered one-cycle rise/fall strobes.
`timescale 1ns/1ps
module sw_debounce #(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst_n,
  sw_debounce_if.slave   bus
);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  logic [WIDTH-1:0] s1_p0;
  logic [WIDTH-1:0] s2_p1;
  logic [WIDTH-1:0] clean_p2;
  logic [WIDTH-1:0] rise_p2;
  logic [WIDTH-1:0] fall_p2;
  logic             changed_p2;

  logic [WIDTH-1:0] clean_nx;
  logic [WIDTH-1:0] rise_nx;
  logic [WIDTH-1:0] fall_nx;

  // Stage p0/p1: two-flop synchroniser; nothing downstream touches s1_p0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= '0;
      s2_p1 <= '0;
    end else begin
      s1_p0 <= bus.sw_raw;
      s2_p1 <= s1_p0;
    end
  end

  // Stage p2: per-bit mismatch counter and acceptance
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    state_t           state_p2;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt_p2;
    logic [CNT_W-1:0] cnt_nx;
    logic             clean_b;
    logic             rise_b;
    logic             fall_b;
    logic             mismatch;

    assign mismatch = (s2_p1[b] != clean_p2[b]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_p2 <= IDLE;
        cnt_p2   <= '0;
      end else begin
        state_p2 <= state_nx;
        cnt_p2   <= cnt_nx;
      end
    end

    always_comb begin
      state_nx = state_p2;
      cnt_nx   = cnt_p2;
      clean_b  = clean_p2[b];
      rise_b   = 1'b0;
      fall_b   = 1'b0;
      case (state_p2)
        IDLE: begin
          // Counter is always zero here, so the first mismatch edge counts as one
          if (mismatch) begin
            state_nx = COUNT;
            cnt_nx   = CNT_ONE;
          end
        end
        COUNT: begin
          if (!mismatch) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt_p2 == CNT_MAX) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            clean_b  = s2_p1[b];
            rise_b   = s2_p1[b];
            fall_b   = ~s2_p1[b];
          end else begin
            cnt_nx = cnt_p2 + CNT_ONE;
          end
        end
      endcase
    end

    assign clean_nx[b] = clean_b;
    assign rise_nx[b]  = rise_b;
    assign fall_nx[b]  = fall_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_p2   <= '0;
      rise_p2    <= '0;
      fall_p2    <= '0;
      changed_p2 <= 1'b0;
    end else begin
      clean_p2   <= clean_nx;
      rise_p2    <= rise_nx;
      fall_p2    <= fall_nx;
      changed_p2 <= |(rise_nx | fall_nx);
    end
  end

  assign bus.sw_clean   = clean_p2;
  assign bus.sw_rise    = rise_p2;
  assign bus.sw_fall    = fall_p2;
  assign bus.sw_changed = changed_p2;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed and random-model bench for sw_debounce with STABLE_CYCLES=8, WIDTH=10.
`timescale 1ns/1ps
module tb_sw_debounce;
  localparam int W  = 10;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  sw_debounce_if #(.WIDTH(W)) dif ();

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  // Advance past the next active edge; outputs are stable 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    dif.sw_raw = '0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3*W:0] got;
    rst_n      = 1'b0;
    dif.sw_raw = '1;
    repeat (4) step();
    got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
    vec_cnt++;
    if (got !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs got=%h exp=%h", got, {(3*W+1){1'b0}});
    end
    dif.sw_raw = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    logic [3*W:0] got, exp;
    logic [W-1:0] ec, er;
    dif.sw_raw = W'(1);
    for (int e = 0; e < 12; e++) begin
      step();
      ec  = (e >= 9) ? W'(1) : '0;
      er  = (e == 9) ? W'(1) : '0;
      exp = {ec, er, {W{1'b0}}, (e == 9)};
      got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL power_up edge=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3*W:0] got, exp;
    logic [W-1:0] ec, er, ef;
    // 7-cycle low pulse must be rejected
    for (int e = 0; e < 20; e++) begin
      dif.sw_raw = (e < 7) ? '0 : W'(1);
      step();
      exp = {W'(1), {W{1'b0}}, {W{1'b0}}, 1'b0};
      got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL glitch7 edge=%0d got=%h exp=%h", e, got, exp);
      end
    end
    // 8-cycle low pulse is accepted, then the restored high is re-acquired
    for (int e = 0; e < 22; e++) begin
      dif.sw_raw = (e < 8) ? '0 : W'(1);
      step();
      ec  = (e < 9 || e >= 17) ? W'(1) : '0;
      er  = (e == 17) ? W'(1) : '0;
      ef  = (e == 9) ? W'(1) : '0;
      exp = {ec, er, ef, (e == 9 || e == 17)};
      got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL glitch8 edge=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3*W:0] got, exp;
    logic [W-1:0] ec, er, r;
    do_reset();
    for (int e = 0; e < 25; e++) begin
      r          = '0;
      r[3]       = (e < 12) ? (((e / 3) % 2) == 0) : 1'b1;
      dif.sw_raw = r;
      step();
      ec  = (e >= 21) ? W'(8) : '0;
      er  = (e == 21) ? W'(8) : '0;
      exp = {ec, er, {W{1'b0}}, (e == 21)};
      got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL bounce edge=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_all_bits();
    logic [3*W:0] got, exp;
    do_reset();
    dif.sw_raw = '1;
    for (int e = 0; e < 12; e++) begin
      step();
      exp = {((e >= 9) ? {W{1'b1}} : {W{1'b0}}), ((e == 9) ? {W{1'b1}} : {W{1'b0}}),
             {W{1'b0}}, (e == 9)};
      got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL all_bits edge=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3*W:0] got, exp;
    do_reset();
    dif.sw_raw = W'(1);
    repeat (10) step();
    got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
    exp = {W'(1), W'(1), {W{1'b0}}, 1'b1};
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL mid_setup got=%h exp=%h", got, exp);
    end
    dif.sw_raw = W'(10'h021);
    repeat (7) step();
    got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
    exp = {W'(1), {W{1'b0}}, {W{1'b0}}, 1'b0};
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL mid_counting got=%h exp=%h", got, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
    vec_cnt++;
    if (got !== '0) begin
      err_cnt++;
      $display("FAIL mid_async_clear got=%h exp=0", got);
    end
    for (int e = 0; e < 3; e++) begin
      step();
      got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
      vec_cnt++;
      if (got !== '0) begin
        err_cnt++;
        $display("FAIL mid_in_reset cyc=%0d got=%h exp=0", e, got);
      end
    end
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      exp = {((e >= 9) ? W'(10'h021) : {W{1'b0}}), ((e == 9) ? W'(10'h021) : {W{1'b0}}),
             {W{1'b0}}, (e == 9)};
      got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL mid_release edge=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] m_s1, m_s2, m_clean, m_rise, m_fall, r;
    logic [3*W:0] got, exp;
    int m_run[W];
    int hold[W];
    do_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; r = '0;
    for (int b = 0; b < W; b++) begin
      m_run[b] = 0;
      hold[b]  = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          r[b]    = ~r[b];
          hold[b] = int'($urandom_range(1, 20));
        end
        hold[b]--;
      end
      dif.sw_raw = r;
      @(posedge clk);
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        if (m_s2[b] == m_clean[b]) begin
          m_run[b] = 0;
        end else if (m_run[b] == SC - 1) begin
          m_clean[b] = m_s2[b];
          m_run[b]   = 0;
          if (m_s2[b]) m_rise[b] = 1'b1;
          else         m_fall[b] = 1'b1;
        end else begin
          m_run[b]++;
        end
      end
      m_s2 = m_s1;
      m_s1 = r;
      #1;
      exp = {m_clean, m_rise, m_fall, |(m_rise | m_fall)};
      got = {dif.sw_clean, dif.sw_rise, dif.sw_fall, dif.sw_changed};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        if (err_cnt < 20) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      vec_cnt++;
      if ((dif.sw_rise & dif.sw_fall) !== '0) begin
        err_cnt++;
        if (err_cnt < 20)
          $display("FAIL rise_fall_overlap cyc=%0d got=%h exp=0", cyc, dif.sw_rise & dif.sw_fall);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    dif.sw_raw = '0;
    test_reset();
    test_power_up();
    test_glitch();
    test_bounce();
    test_all_bits();
    test_reset_mid_count();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
